// File: rtl/fire_zone_ctrl.sv
// fire_zone_ctrl: per-zone fire detection, confirmation and extinguish control.
// Debounces raw smoke/heat per zone and runs an independent FSM per zone.
// Ports: clk, reset (async active-low), smoke_signal/heat_signal [ZONES],
//   ack (operator acknowledge), alarm (any zone), alarm_zone/extinguish [ZONES].
// Build option: define FIRE_ACK_LATCH_EN to hold a zone in LATCHED after
//   extinguishing until ack with smoke clear; otherwise it returns to IDLE.
module fire_zone_ctrl #(
  parameter int ZONES          = 4,
  parameter int DEBOUNCE       = 3,
  parameter int CONFIRM_CYCLES = 8,
  parameter int EXT_CYCLES     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ZONES-1:0] smoke_signal,
  input  logic [ZONES-1:0] heat_signal,
  input  logic             ack,
  output logic             alarm,
  output logic [ZONES-1:0] alarm_zone,
  output logic [ZONES-1:0] extinguish
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ALARM   = 2'b01,
    EXTING  = 2'b10
`ifdef FIRE_ACK_LATCH_EN
    ,
    LATCHED = 2'b11
`endif
  } zone_state_e;

  localparam logic [7:0]  DB_LAST  = 8'(DEBOUNCE - 1);
  localparam logic [7:0]  CF_LAST  = 8'(CONFIRM_CYCLES - 1);
  localparam logic [15:0] EXT_LOAD = 16'(EXT_CYCLES);

  logic [ZONES-1:0] smoke_db;
  logic [ZONES-1:0] heat_db;
  logic [ZONES-1:0] both;
  logic [7:0]       smoke_cnt [ZONES];
  logic [7:0]       heat_cnt  [ZONES];

  zone_state_e      state_q [ZONES];
  zone_state_e      state_d [ZONES];
  logic [7:0]       conf_q  [ZONES];
  logic [7:0]       conf_d  [ZONES];
  logic [15:0]      tmr_q   [ZONES];
  logic [15:0]      tmr_d   [ZONES];
  logic [ZONES-1:0] az_d;
  logic [ZONES-1:0] ext_d;

`ifndef FIRE_ACK_LATCH_EN
  logic ack_unused;
  assign ack_unused = ack;
`endif

  assign both = smoke_db & heat_db;

  // A debounced value only moves after DEBOUNCE consecutive
  // disagreeing samples; one agreeing sample restarts the run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smoke_db <= '0;
      heat_db  <= '0;
      for (int z = 0; z < ZONES; z++) begin
        smoke_cnt[z] <= '0;
        heat_cnt[z]  <= '0;
      end
    end else begin
      for (int z = 0; z < ZONES; z++) begin
        if (smoke_signal[z] == smoke_db[z]) begin
          smoke_cnt[z] <= '0;
        end else if (smoke_cnt[z] == DB_LAST) begin
          smoke_db[z]  <= smoke_signal[z];
          smoke_cnt[z] <= '0;
        end else begin
          smoke_cnt[z] <= smoke_cnt[z] + 8'd1;
        end
        if (heat_signal[z] == heat_db[z]) begin
          heat_cnt[z] <= '0;
        end else if (heat_cnt[z] == DB_LAST) begin
          heat_db[z]  <= heat_signal[z];
          heat_cnt[z] <= '0;
        end else begin
          heat_cnt[z] <= heat_cnt[z] + 8'd1;
        end
      end
    end
  end

  always_comb begin
    az_d  = '0;
    ext_d = '0;
    for (int z = 0; z < ZONES; z++) begin
      state_d[z] = IDLE;
      conf_d[z]  = '0;
      tmr_d[z]   = '0;
      case (state_q[z])
        IDLE: begin
          if (smoke_db[z]) state_d[z] = ALARM;
        end
        ALARM: begin
          if (!smoke_db[z]) begin
            state_d[z] = IDLE;
          end else if (both[z] && conf_q[z] == CF_LAST) begin
            state_d[z] = EXTING;
            tmr_d[z]   = EXT_LOAD;
          end else begin
            state_d[z] = ALARM;
            conf_d[z]  = both[z] ? conf_q[z] + 8'd1 : 8'd0;
          end
        end
        EXTING: begin
          // Timer at 1 means it expires on this edge.
          if (tmr_q[z] > 16'd1) begin
            state_d[z] = EXTING;
            tmr_d[z]   = tmr_q[z] - 16'd1;
          end else if (both[z]) begin
            state_d[z] = EXTING;
            tmr_d[z]   = EXT_LOAD;
          end else begin
`ifdef FIRE_ACK_LATCH_EN
            state_d[z] = LATCHED;
`else
            state_d[z] = IDLE;
`endif
          end
        end
`ifdef FIRE_ACK_LATCH_EN
        LATCHED: begin
          if (ack && !smoke_db[z]) begin
            state_d[z] = IDLE;
          end else if (both[z]) begin
            state_d[z] = ALARM;
          end else begin
            state_d[z] = LATCHED;
          end
        end
`endif
        default: state_d[z] = IDLE;
      endcase
      az_d[z]  = (state_d[z] != IDLE);
      ext_d[z] = (state_d[z] == EXTING);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm      <= 1'b0;
      alarm_zone <= '0;
      extinguish <= '0;
      for (int z = 0; z < ZONES; z++) begin
        state_q[z] <= IDLE;
        conf_q[z]  <= '0;
        tmr_q[z]   <= '0;
      end
    end else begin
      alarm      <= |az_d;
      alarm_zone <= az_d;
      extinguish <= ext_d;
      for (int z = 0; z < ZONES; z++) begin
        state_q[z] <= state_d[z];
        conf_q[z]  <= conf_d[z];
        tmr_q[z]   <= tmr_d[z];
      end
    end
  end

endmodule
